// File: rtl/dmem_arbiter_if.sv
// Requester-side bus for dmem_arbiter: one instance per port.
// The master modport is the requester (LSU or DMA); the slave modport is the arbiter.
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int DATA_BYTES = DATA_WIDTH / 8
);
    logic                  req;
    logic                  gnt;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_BYTES-1:0] wen;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req, addr, wdata, wen,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, wdata, wen,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core LSU (port 0)
// and the loader/debug DMA (port 1). Port 0 has fixed priority; a starvation
// counter forces one port 1 grant after STARVE_LIMIT consecutive port 0 grants
// while port 1 waits. Responses return one cycle after grant, matching the
// memory's 1-cycle synchronous read (write-first).
// Optional build macro: DMEM_ARB_STATS_EN adds grant statistics counters.
module dmem_arbiter #(
    parameter int DATA_WIDTH   = 64,
    parameter int DATA_BYTES   = DATA_WIDTH / 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_arbiter_if.slave         p0,
    dmem_arbiter_if.slave         p1,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_BYTES-1:0] mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]           stat_gnt0,
    output logic [31:0]           stat_gnt1,
    output logic [15:0]           stat_forced
`endif
);

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    localparam logic [7:0] LP_LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] r_starve_cnt;
    logic       r_rsp_valid;
    port_e      r_rsp_id;

    logic       w_force;
    logic       w_gnt0;
    logic       w_gnt1;

    // Port 1 is forced only when both ports contend and port 1 has waited long enough.
    assign w_force = p0.req && p1.req && (r_starve_cnt >= LP_LIMIT);

    // Grant decision from registered state; nothing is granted while in reset.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned, which would infer a latch.
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            if (p0.req && !w_force) begin
                w_gnt0 = 1'b1;
            end else if (p1.req) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    assign p0.gnt = w_gnt0;
    assign p1.gnt = w_gnt1;

    // Pass the granted port's command to memory; idle cycles issue a harmless read of word 0.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wen   = '0;
        if (w_gnt0) begin
            mem_addr  = p0.addr;
            mem_wdata = p0.wdata;
            mem_wen   = p0.wen;
        end else if (w_gnt1) begin
            mem_addr  = p1.addr;
            mem_wdata = p1.wdata;
            mem_wen   = p1.wen;
        end
    end

    // Starvation counter: counts port 0 wins while port 1 waits, saturating at 255.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values, independent of statement order.
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (w_gnt1 || !p1.req) begin
            r_starve_cnt <= '0;
        end else if (w_gnt0 && (r_starve_cnt != 8'hFF)) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end

    // Response pipeline: remember whether and to whom a grant was issued this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= PORT0;
        end else begin
            r_rsp_valid <= w_gnt0 || w_gnt1;
            r_rsp_id    <= w_gnt1 ? PORT1 : PORT0;
        end
    end

    // Responses are masked by rst so a transaction issued just before reset never acknowledges.
    assign p0.rvalid = r_rsp_valid && !rst && (r_rsp_id == PORT0);
    assign p1.rvalid = r_rsp_valid && !rst && (r_rsp_id == PORT1);
    assign p0.rdata  = p0.rvalid ? mem_rdata : '0;
    assign p1.rdata  = p1.rvalid ? mem_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
    // Grant statistics; counters wrap at their maximum value.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_gnt0   <= '0;
            stat_gnt1   <= '0;
            stat_forced <= '0;
        end else begin
            if (w_gnt0) begin
                stat_gnt0 <= stat_gnt0 + 32'd1;
            end
            if (w_gnt1) begin
                stat_gnt1 <= stat_gnt1 + 32'd1;
            end
            if (w_gnt1 && w_force) begin
                stat_forced <= stat_forced + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: table-driven per-cycle vectors with a
// response scoreboard and a write-first memory model behind the arbiter.
module tb_dmem_arbiter;

    localparam int DW = 64;
    localparam int DB = 8;

    logic          clk;
    logic          rst;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DB-1:0] mem_wen;
    logic [DW-1:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0]   stat_gnt0;
    logic [31:0]   stat_gnt1;
    logic [15:0]   stat_forced;
`endif

    dmem_arbiter_if #(.DATA_WIDTH(DW), .DATA_BYTES(DB)) p0_if ();
    dmem_arbiter_if #(.DATA_WIDTH(DW), .DATA_BYTES(DB)) p1_if ();

    dmem_arbiter #(
        .DATA_WIDTH  (DW),
        .DATA_BYTES  (DB),
        .STARVE_LIMIT(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .p0         (p0_if.slave),
        .p1         (p1_if.slave),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wen    (mem_wen),
        .mem_rdata  (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_gnt0  (stat_gnt0),
        .stat_gnt1  (stat_gnt1),
        .stat_forced(stat_forced)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [DB-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int i = 0; i < DB; i++) begin
            if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return r;
    endfunction

    // Memory environment: 1-cycle synchronous read, write-first.
    logic [DW-1:0] mem_model [logic [60:0]];
    always @(posedge clk) begin
        logic [DW-1:0] w;
        w = mem_model.exists(mem_addr[63:3]) ? mem_model[mem_addr[63:3]] : '0;
        if (mem_wen != '0) begin
            w = merge(w, mem_wdata, mem_wen);
            mem_model[mem_addr[63:3]] = w;
        end
        mem_rdata <= w;
    end

    typedef struct {
        bit            r;
        bit            q0;
        bit            q1;
        logic [DW-1:0] a0;
        logic [DW-1:0] d0;
        logic [DB-1:0] w0;
        logic [DW-1:0] a1;
        logic [DW-1:0] d1;
        logic [DB-1:0] w1;
        bit            g0;
        bit            g1;
    } vec_t;

    typedef struct {
        bit            valid;
        bit            port;
        logic [DW-1:0] data;
    } rsp_t;

    vec_t          vecs[$];
    rsp_t          sb[$];
    logic [DW-1:0] shadow [logic [60:0]];
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input bit r, input bit q0, input bit q1,
                                input logic [DW-1:0] a0, input logic [DW-1:0] d0, input logic [DB-1:0] w0,
                                input logic [DW-1:0] a1, input logic [DW-1:0] d1, input logic [DB-1:0] w1,
                                input bit g0, input bit g1);
        vec_t v;
        v.r = r; v.q0 = q0; v.q1 = q1;
        v.a0 = a0; v.d0 = d0; v.w0 = w0;
        v.a1 = a1; v.d1 = d1; v.w1 = w1;
        v.g0 = g0; v.g1 = g1;
        return v;
    endfunction

    // One cycle: drive at negedge, check last cycle's response and this cycle's grant/mem drive.
    task automatic apply(input vec_t v);
        rsp_t          e;
        rsp_t          n;
        logic [DW-1:0] ea, ed, wd;
        logic [DB-1:0] ew;
        @(negedge clk);
        rst         = v.r;
        p0_if.req   = v.q0; p0_if.addr = v.a0; p0_if.wdata = v.d0; p0_if.wen = v.w0;
        p1_if.req   = v.q1; p1_if.addr = v.a1; p1_if.wdata = v.d1; p1_if.wen = v.w1;
        #1;
        e = sb.pop_front();
        if (v.r) e.valid = 1'b0;
        check("p0_rvalid", DW'(p0_if.rvalid), DW'(e.valid && !e.port));
        check("p1_rvalid", DW'(p1_if.rvalid), DW'(e.valid && e.port));
        check("p0_rdata", p0_if.rdata, (e.valid && !e.port) ? e.data : '0);
        check("p1_rdata", p1_if.rdata, (e.valid && e.port) ? e.data : '0);
        check("p0_gnt", DW'(p0_if.gnt), DW'(v.g0));
        check("p1_gnt", DW'(p1_if.gnt), DW'(v.g1));
        ea = '0; ed = '0; ew = '0;
        if (v.g0) begin
            ea = v.a0; ed = v.d0; ew = v.w0;
        end else if (v.g1) begin
            ea = v.a1; ed = v.d1; ew = v.w1;
        end
        check("mem_addr", mem_addr, ea);
        check("mem_wdata", mem_wdata, ed);
        check("mem_wen", DW'(mem_wen), DW'(ew));
        n.valid = v.g0 || v.g1;
        n.port  = v.g1;
        n.data  = '0;
        if (n.valid) begin
            wd = shadow.exists(ea[63:3]) ? shadow[ea[63:3]] : '0;
            if (ew != '0) begin
                wd = merge(wd, ed, ew);
                shadow[ea[63:3]] = wd;
            end
            n.data = wd;
        end
        sb.push_back(n);
    endtask

    localparam logic [DW-1:0] Z = '0;

    initial begin
        rst = 1'b1;
        p0_if.req = 1'b0; p0_if.addr = '0; p0_if.wdata = '0; p0_if.wen = '0;
        p1_if.req = 1'b0; p1_if.addr = '0; p1_if.wdata = '0; p1_if.wen = '0;
        sb.push_back('{valid: 1'b0, port: 1'b0, data: '0});

        // Reset for two cycles with both ports requesting: nothing granted.
        for (int i = 0; i < 2; i++)
            vecs.push_back(mk(1, 1, 1, 64'h10, 64'h1, 8'hFF, 64'h10, Z, 8'h00, 0, 0));
        // Continuous contention right after reset: 0,0,0,0,1,0,0,0,0,1.
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(0, 1, 1, 64'h10, 64'hC0DE_0000_0000_0000 | 64'(i), 8'hFF,
                              64'h10, Z, 8'h00, (i % 5) != 4, (i % 5) == 4));
        foreach (vecs[i]) apply(vecs[i]);
        vecs.delete();

`ifdef DMEM_ARB_STATS_EN
        @(posedge clk); #1;
        check("stat_gnt0", DW'(stat_gnt0), 64'd8);
        check("stat_gnt1", DW'(stat_gnt1), 64'd2);
        check("stat_forced", DW'(stat_forced), 64'd2);
`endif

        // Single-port traffic, byte writes, sim-control addresses, starve clear.
        vecs.push_back(mk(0, 1, 0, 64'h100, 64'hDEADBEEF_00000001, 8'hFF, Z, Z, 8'h00, 1, 0));
        vecs.push_back(mk(0, 1, 0, 64'h100, Z, 8'h00, Z, Z, 8'h00, 1, 0));
        vecs.push_back(mk(0, 0, 0, Z, Z, 8'h00, Z, Z, 8'h00, 0, 0));
        vecs.push_back(mk(0, 0, 1, Z, Z, 8'h00, 64'h208, 64'h11223344_55667788, 8'hFF, 0, 1));
        vecs.push_back(mk(0, 0, 1, Z, Z, 8'h00, 64'h208, 64'h0000_00AA, 8'h01, 0, 1));
        vecs.push_back(mk(0, 0, 1, Z, Z, 8'h00, 64'h208, Z, 8'h00, 0, 1));
        vecs.push_back(mk(0, 1, 0, 64'h40, Z, 8'h00, Z, Z, 8'h00, 1, 0));
        vecs.push_back(mk(0, 0, 1, Z, Z, 8'h00, 64'h50, 64'h3, 8'hFF, 0, 1));
        vecs.push_back(mk(0, 1, 1, 64'h100, Z, 8'h00, 64'h208, Z, 8'h00, 1, 0));
        vecs.push_back(mk(0, 1, 1, 64'h100, Z, 8'h00, 64'h208, Z, 8'h00, 1, 0));
        vecs.push_back(mk(0, 1, 0, 64'h100, Z, 8'h00, Z, Z, 8'h00, 1, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 1, 1, 64'h60, Z, 8'h00, 64'h100, Z, 8'h00, i != 4, i == 4));
        vecs.push_back(mk(0, 0, 0, Z, Z, 8'h00, Z, Z, 8'h00, 0, 0));
        foreach (vecs[i]) apply(vecs[i]);
        vecs.delete();

        // Reset mid-operation: pending response dropped, write during reset not issued,
        // starvation count restarts from zero afterwards.
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 1, 1, 64'h100, Z, 8'h00, 64'h208, Z, 8'h00, 1, 0));
        vecs.push_back(mk(1, 1, 1, 64'h500, 64'h5555_5555, 8'hFF, 64'h208, Z, 8'h00, 0, 0));
        vecs.push_back(mk(1, 1, 1, 64'h500, 64'h5555_5555, 8'hFF, 64'h208, Z, 8'h00, 0, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 1, 1, 64'h500, Z, 8'h00, 64'h208, Z, 8'h00, i != 4, i == 4));
        vecs.push_back(mk(0, 0, 0, Z, Z, 8'h00, Z, Z, 8'h00, 0, 0));
        vecs.push_back(mk(0, 0, 0, Z, Z, 8'h00, Z, Z, 8'h00, 0, 0));
        foreach (vecs[i]) apply(vecs[i]);
        vecs.delete();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
